dmi_arbiter: RTL and testbench

DMI_ARBITER -- requirements
Module: dmi_arbiter

---
 rtl/dm_pkg.sv | 8 +
 rtl/dmi_arb_id_fifo.sv | 52 +++++
 rtl/dmi_arbiter.sv | 118 +++++++++++
 tb/tb_dmi_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// DTM operation encodings shared between DMI requesters and the debug module.
package dm;
   typedef enum logic [1:0] {
      DTM_NOP   = 2'h0,
      DTM_READ  = 2'h1,
      DTM_WRITE = 2'h2
   } dtm_op_e;
endpackage

// File: rtl/dmi_arb_id_fifo.sv
// Requester-ID FIFO: remembers which requester owns each outstanding DMI request.
// The head is combinational so responses can be routed in the cycle they arrive.
module dmi_arb_id_fifo #(
   parameter int unsigned Width = 1,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter that shares one downstream DMI port among NumReq requesters,
// routing responses back in request order through an ID FIFO.
module dmi_arbiter
   import dm::*;
#(
   parameter int unsigned NumReq         = 2,
   parameter int unsigned AddrWidth      = 7,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumReq-1:0][AddrWidth-1:0] up_q_addr_i,
   input  dtm_op_e [NumReq-1:0]             up_q_op_i,
   input  logic [NumReq-1:0][31:0]          up_q_data_i,
   input  logic [NumReq-1:0]                up_q_valid_i,
   output logic [NumReq-1:0]                up_q_ready_o,
   output logic [NumReq-1:0][31:0]          up_p_data_o,
   output logic [NumReq-1:0]                up_p_resp_o,
   output logic [NumReq-1:0]                up_p_valid_o,
   input  logic [NumReq-1:0]                up_p_ready_i,
   output logic [AddrWidth-1:0]             dn_q_addr_o,
   output dtm_op_e                          dn_q_op_o,
   output logic [31:0]                      dn_q_data_o,
   output logic                             dn_q_valid_o,
   input  logic                             dn_q_ready_i,
   input  logic [31:0]                      dn_p_data_i,
   input  logic                             dn_p_resp_i,
   input  logic                             dn_p_valid_i,
   output logic                             dn_p_ready_o
);
   localparam int unsigned IdxW = $clog2(NumReq);
   typedef logic [IdxW-1:0] idx_t;

   idx_t rr_q, lock_idx_q, arb_idx, g, head;
   logic lock_q, orphan_q, arb_found, granted, active;
   logic fifo_full, fifo_empty, fifo_live, q_hs, p_hs;
   int   cand;

   assign active = ~rst_i;

   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = 0;
      for (int k = 0; k < int'(NumReq); k++) begin
         cand = (int'(rr_q) + k) % int'(NumReq);
         if (!arb_found && up_q_valid_i[cand]) begin
            arb_found = 1'b1;
            arb_idx   = idx_t'(cand);
         end
      end
   end

   // A stalled request keeps its grant so the downstream fields cannot change under it.
   assign g       = lock_q ? lock_idx_q : arb_idx;
   assign granted = active & (lock_q | arb_found);

   assign dn_q_valid_o = granted & ~fifo_full;
   assign dn_q_addr_o  = up_q_addr_i[g];
   assign dn_q_op_o    = up_q_op_i[g];
   assign dn_q_data_o  = up_q_data_i[g];
   assign q_hs         = dn_q_valid_o & dn_q_ready_i;

   assign fifo_live    = active & ~fifo_empty;
   assign dn_p_ready_o = fifo_live ? up_p_ready_i[head] : 1'b1;
   assign p_hs         = fifo_live & dn_p_valid_i & dn_p_ready_o;

   for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
      assign up_q_ready_o[gi] = dn_q_valid_o & dn_q_ready_i & (g == idx_t'(gi));
      assign up_p_valid_o[gi] = fifo_live & dn_p_valid_i & (head == idx_t'(gi));
      assign up_p_data_o[gi]  = dn_p_data_i;
      assign up_p_resp_o[gi]  = dn_p_resp_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         orphan_q   <= 1'b0;
      end else begin
         if (q_hs) begin
            rr_q   <= (g == idx_t'(NumReq - 1)) ? '0 : g + 1'b1;
            lock_q <= 1'b0;
         end else if (dn_q_valid_o) begin
            lock_q     <= 1'b1;
            lock_idx_q <= g;
         end
         if (dn_p_valid_i && fifo_empty) orphan_q <= 1'b1;
      end
   end

   dmi_arb_id_fifo #(
      .Width (IdxW),
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (q_hs),
      .data_i  (g),
      .pop_i   (p_hs),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

`ifndef SYNTHESIS
   a_dn_q_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      dn_q_valid_o && !dn_q_ready_i |=> dn_q_valid_o && $stable(dn_q_addr_o)
                                        && $stable(dn_q_op_o) && $stable(dn_q_data_o));
   a_orphan_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
      orphan_q |=> orphan_q);
   for (genvar gi = 0; gi < NumReq; gi++) begin : g_p_chk
      a_up_p_stable: assert property (@(posedge clk_i) disable iff (rst_i)
         up_p_valid_o[gi] && !up_p_ready_i[gi] |=> up_p_valid_o[gi] && $stable(up_p_data_o[gi]));
   end
`endif
endmodule

// File: tb/tb_dmi_arbiter.sv
// Scenario bench for dmi_arbiter: expected grants and responses are queued when
// stimulus is driven and compared by a negedge monitor at each handshake.
module tb_dmi_arbiter;
   localparam int NR = 2;
   localparam int AW = 7;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NR-1:0][AW-1:0]  up_q_addr;
   dm::dtm_op_e [NR-1:0]   up_q_op;
   logic [NR-1:0][31:0]    up_q_data;
   logic [NR-1:0]          up_q_valid, up_q_ready;
   logic [NR-1:0][31:0]    up_p_data;
   logic [NR-1:0]          up_p_resp, up_p_valid, up_p_ready;
   logic [AW-1:0]          dn_q_addr;
   dm::dtm_op_e            dn_q_op;
   logic [31:0]            dn_q_data, dn_p_data;
   logic                   dn_q_valid, dn_q_ready, dn_p_resp, dn_p_valid, dn_p_ready;

   typedef struct { int idx; logic [31:0] a; logic [31:0] d; } item_t;
   item_t exp_q[$];
   item_t exp_p[$];
   int    n_total = 0;
   int    n_bad   = 0;

   always #5 clk = ~clk;

   dmi_arbiter #(.NumReq(NR), .AddrWidth(AW), .MaxOutstanding(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .up_q_addr_i(up_q_addr), .up_q_op_i(up_q_op), .up_q_data_i(up_q_data),
      .up_q_valid_i(up_q_valid), .up_q_ready_o(up_q_ready),
      .up_p_data_o(up_p_data), .up_p_resp_o(up_p_resp),
      .up_p_valid_o(up_p_valid), .up_p_ready_i(up_p_ready),
      .dn_q_addr_o(dn_q_addr), .dn_q_op_o(dn_q_op), .dn_q_data_o(dn_q_data),
      .dn_q_valid_o(dn_q_valid), .dn_q_ready_i(dn_q_ready),
      .dn_p_data_i(dn_p_data), .dn_p_resp_i(dn_p_resp),
      .dn_p_valid_i(dn_p_valid), .dn_p_ready_o(dn_p_ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h @%0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %h @%0t", tag, got, $time);
      end
   endtask

   function automatic int onehot_idx(input logic [NR-1:0] v);
      int r = -1;
      for (int i = 0; i < NR; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a);
      up_q_valid[i] = v;
      up_q_addr[i]  = a;
      up_q_op[i]    = dm::DTM_WRITE;
      up_q_data[i]  = 32'h5000_0000 | 32'(a);
   endtask

   task automatic expect_q(input int i, input logic [AW-1:0] a);
      item_t it;
      it.idx = i; it.a = 32'(a); it.d = 32'h5000_0000 | 32'(a);
      exp_q.push_back(it);
   endtask

   task automatic respond(input logic v, input logic [31:0] d, input int owner);
      item_t it;
      dn_p_valid = v;
      dn_p_data  = d;
      if (owner >= 0) begin
         it.idx = owner; it.a = '0; it.d = d;
         exp_p.push_back(it);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every handshake must match the oldest expectation.
   always @(negedge clk) begin
      item_t it;
      if (!rst) begin
         if (dn_q_valid && dn_q_ready) begin
            if (exp_q.size() == 0) chk("q_unexpected", 32'd1, 32'd0);
            else begin
               it = exp_q.pop_front();
               chk("q_idx",  32'(onehot_idx(up_q_ready)), 32'(it.idx));
               chk("q_addr", 32'(dn_q_addr), it.a);
               chk("q_data", dn_q_data, it.d);
            end
         end
         if ((up_p_valid & up_p_ready) != '0) begin
            if (exp_p.size() == 0) chk("p_unexpected", 32'd1, 32'd0);
            else begin
               it = exp_p.pop_front();
               chk("p_idx",  32'(onehot_idx(up_p_valid & up_p_ready)), 32'(it.idx));
               chk("p_data", up_p_data[it.idx], it.d);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      up_q_valid = '0; up_q_addr = '0; up_q_data = '0;
      up_q_op = {dm::DTM_NOP, dm::DTM_NOP};
      up_p_ready = '1; dn_q_ready = 1'b0;
      dn_p_valid = 1'b0; dn_p_data = '0; dn_p_resp = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dn_q_valid", 32'(dn_q_valid), 32'd0);
      chk("rst_up_q_ready", 32'(up_q_ready), 32'd0);
      chk("rst_up_p_valid", 32'(up_p_valid), 32'd0);
      chk("rst_dn_p_ready", 32'(dn_p_ready), 32'd1);
      next_cycle();
      rst = 1'b0;

      // Both requesters contend; responses drain one per cycle so the FIFO never fills.
      dn_q_ready = 1'b1;
      set_req(0, 1'b1, 7'h01); set_req(1, 1'b1, 7'h02);
      expect_q(0, 7'h01);
      next_cycle();
      expect_q(1, 7'h02); respond(1'b1, 32'h1000, 0);
      next_cycle();
      expect_q(0, 7'h01); respond(1'b1, 32'h1001, 1);
      next_cycle();
      set_req(0, 1'b0, 7'h01);
      expect_q(1, 7'h02); respond(1'b1, 32'h1002, 0);
      next_cycle();
      set_req(1, 1'b0, 7'h02);
      respond(1'b1, 32'h1003, 1);
      next_cycle();
      respond(1'b0, 32'h0, -1);

      // Stall with req1 granted while rr points at req0; req0 arrives mid-stall.
      dn_q_ready = 1'b0;
      set_req(1, 1'b1, 7'h10);
      for (int c = 0; c < 3; c++) begin
         if (c == 1) set_req(0, 1'b1, 7'h20);
         @(negedge clk);
         chk("stall_addr",  32'(dn_q_addr), 32'h10);
         chk("stall_valid", 32'(dn_q_valid), 32'd1);
         next_cycle();
      end
      dn_q_ready = 1'b1;
      expect_q(1, 7'h10);
      next_cycle();
      set_req(1, 1'b0, 7'h10);
      expect_q(0, 7'h20);
      next_cycle();
      set_req(0, 1'b0, 7'h20);

      // Two IDs outstanding: a third request must wait until a response pops.
      set_req(1, 1'b1, 7'h30);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("full_dn_q_valid", 32'(dn_q_valid), 32'd0);
         chk("full_up_q_ready", 32'(up_q_ready), 32'd0);
         next_cycle();
      end
      respond(1'b1, 32'hAAAA, 1);
      @(negedge clk);
      chk("full_pop_cycle_valid", 32'(dn_q_valid), 32'd0);
      next_cycle();
      respond(1'b1, 32'hBBBB, 0);
      expect_q(1, 7'h30);
      @(negedge clk);
      chk("after_pop_valid", 32'(dn_q_valid), 32'd1);
      next_cycle();
      set_req(1, 1'b0, 7'h30);

      // Head requester (1) holds off its response for two cycles.
      up_p_ready = 2'b01;
      respond(1'b1, 32'hCCCC, -1);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("bp_dn_p_ready", 32'(dn_p_ready), 32'd0);
         chk("bp_up_p_valid", 32'(up_p_valid), 32'h2);
         next_cycle();
      end
      up_p_ready = 2'b11;
      respond(1'b1, 32'hCCCC, 1);
      @(negedge clk);
      chk("bp_release_ready", 32'(dn_p_ready), 32'd1);
      next_cycle();
      respond(1'b0, 32'h0, -1);

      // Reset with one ID outstanding; the late response becomes an orphan.
      set_req(0, 1'b1, 7'h40);
      expect_q(0, 7'h40);
      next_cycle();
      set_req(0, 1'b0, 7'h40);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_dn_p_ready", 32'(dn_p_ready), 32'd1);
      chk("mid_rst_up_p_valid", 32'(up_p_valid), 32'd0);
      next_cycle();
      rst = 1'b0;
      respond(1'b1, 32'hDEAD, -1);
      @(negedge clk);
      chk("orphan_up_p_valid", 32'(up_p_valid), 32'd0);
      chk("orphan_dn_p_ready", 32'(dn_p_ready), 32'd1);
      chk("orphan_flag_before", 32'(dut.orphan_q), 32'd0);
      next_cycle();
      respond(1'b0, 32'h0, -1);
      @(negedge clk);
      chk("orphan_flag_after", 32'(dut.orphan_q), 32'd1);

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("exp_p_drained", 32'(exp_p.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
